// File: rtl/dsp48_pkg.sv
// Shared constants and helpers for the DSP48A1 operand/control pipeline registers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dsp48_pkg;

  // Deepest operand pipeline any DSP48A1 path uses.
  localparam int MAX_PIPE_DEPTH = 8;

  // Default reset value for data stages; sliced down to each instance's WIDTH.
  localparam logic [47:0] DEFAULT_RST_VAL = 48'h0;

  // Width of an occupancy counter that must hold 0..depth; never narrower than 1 bit.
  function automatic int cnt_w(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_stage.sv
// One pipeline flop stage carrying WIDTH data bits plus a valid bit.
// Latency: 1 enabled clock.
// Backpressure: none; clken stalls the stage, clear drops the valid bit only.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   clken          stage captures only when high
//   clear          synchronous valid clear (data path unaffected)
//   in_data/valid  upstream stage contents
//   out_data/valid registered stage contents
module reg_stage
  import dsp48_pkg::*;
#(
  parameter int               WIDTH   = 18,
  parameter logic [WIDTH-1:0] RST_VAL = DEFAULT_RST_VAL[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clken,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= RST_VAL;
      out_valid <= 1'b0;
    end else begin
      // Data keeps shifting during a clear so the datapath timing is unchanged;
      // only the qualifier is dropped.
      if (clken) begin
        out_data <= in_data;
      end
      if (clear) begin
        out_valid <= 1'b0;
      end else if (clken) begin
        out_valid <= in_valid;
      end
    end
  end

endmodule

// File: rtl/reg_pipe_sync.sv
// Parametrised operand pipeline register (0..8 stages) with valid shadow, flush and occupancy.
// Latency: DEPTH enabled clocks (DEPTH=0 is a combinational bypass).
// Backpressure: none; input is always accepted, clken=0 stalls every stage together.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   clken               pipeline advances only when high
//   flush               synchronous; clears all valid bits, data untouched
//   in_data, in_valid   operand and qualifier
//   out_data, out_valid operand after DEPTH enabled cycles
//   occupancy           number of stages currently holding valid data
module reg_pipe_sync
  import dsp48_pkg::*;
#(
  parameter int               WIDTH   = 18,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = DEFAULT_RST_VAL[WIDTH-1:0],
  localparam int              CNT_W   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clken,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] occupancy
);

  if (DEPTH < 0 || DEPTH > MAX_PIPE_DEPTH || WIDTH < 1) begin : g_bad_cfg
    $fatal(1, "reg_pipe_sync: unsupported configuration (DEPTH must be 0..8, WIDTH >= 1)");
  end

  if (DEPTH == 0) begin : g_bypass
    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign occupancy = '0;

    // Control inputs have no function in bypass mode.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, clken, flush};
  end else begin : g_pipe
    // Index 0 is the pipeline input; index k is the output of stage k-1.
    logic [WIDTH-1:0] d [0:DEPTH];
    logic             v [0:DEPTH];
    logic [DEPTH-1:0] v_bits;
    logic [CNT_W-1:0] occ;

    assign d[0] = in_data;
    assign v[0] = in_valid;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      reg_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .clear     (flush),
        .in_data   (d[k]),
        .in_valid  (v[k]),
        .out_data  (d[k+1]),
        .out_valid (v[k+1])
      );
      assign v_bits[k] = v[k+1];
    end

    // Tracked incrementally rather than as a popcount so the output is a flop.
    // Entry and exit in the same cycle cancel, so a full pipe stays at DEPTH.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        occ <= '0;
      end else if (clken) begin
        case ({in_valid, v[DEPTH]})
          2'b10:   occ <= occ + CNT_W'(1);
          2'b01:   occ <= occ - CNT_W'(1);
          default: occ <= occ;
        endcase
      end
    end

    assign out_data  = d[DEPTH];
    assign out_valid = v[DEPTH];
    assign occupancy = occ;

    a_occ_popcount: assert property (@(posedge clk) disable iff (reset)
      int'(occ) == $countones(v_bits));
    a_occ_range: assert property (@(posedge clk) disable iff (reset)
      int'(occ) <= DEPTH);
  end

endmodule

// File: tb/tb_reg_pipe_sync.sv
module tb_reg_pipe_sync;

  localparam int          W  = 18;
  localparam int          D  = 3;
  localparam logic [17:0] RV = 18'h155;

  localparam int EK_HOLD  = 0;
  localparam int EK_EN    = 1;
  localparam int EK_FLUSH = 2;
  localparam int EK_RESET = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clken = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic [1:0]   occupancy;

  logic         byp_reset = 1'b0;
  logic         byp_clken = 1'b0;
  logic         byp_flush = 1'b0;
  logic [W-1:0] byp_in_data = '0;
  logic         byp_in_valid = 1'b0;
  logic [W-1:0] byp_out_data;
  logic         byp_out_valid;
  logic [0:0]   byp_occupancy;

  always #5 clk = ~clk;

  reg_pipe_sync #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .occupancy (occupancy)
  );

  reg_pipe_sync #(.WIDTH(W), .DEPTH(0)) u_byp (
    .clk       (clk),
    .reset     (byp_reset),
    .clken     (byp_clken),
    .flush     (byp_flush),
    .in_data   (byp_in_data),
    .in_valid  (byp_in_valid),
    .out_data  (byp_out_data),
    .out_valid (byp_out_valid),
    .occupancy (byp_occupancy)
  );

  // Reference model: every accepted valid item is due at the output once the
  // count of enabled edges reaches (enabled edges before entry) + D.
  typedef struct {
    logic [W-1:0] data;
    int           due;
  } item_t;

  item_t exp_q[$];     // scoreboard: items still to appear on the output
  int    inflight[$];  // due counts of items still inside the pipe
  int    en_cnt    = 0;
  int    edge_kind = EK_HOLD;
  bit    started   = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: inputs applied at the falling edge, model advanced at the rising edge.
  task automatic drive(input logic r, input logic f, input logic c, input logic v,
                       input logic [W-1:0] d);
    @(negedge clk);
    reset = r; flush = f; clken = c; in_valid = v; in_data = d;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      inflight.delete();
      edge_kind = EK_RESET;
      started   = 1;
    end else if (f) begin
      exp_q.delete();
      inflight.delete();
      if (c) en_cnt++;
      edge_kind = EK_FLUSH;
    end else if (c) begin
      if (v) begin
        exp_q.push_back('{data: d, due: en_cnt + D});
        inflight.push_back(en_cnt + D);
      end
      en_cnt++;
      while (inflight.size() > 0 && inflight[0] < en_cnt) void'(inflight.pop_front());
      edge_kind = EK_EN;
    end else begin
      edge_kind = EK_HOLD;
    end
  endtask

  // Monitor: decides what should be visible after the latest edge and compares.
  logic         vis_valid = 1'b0;
  logic [W-1:0] vis_data  = '0;

  always @(negedge clk) begin
    if (started) begin
      case (edge_kind)
        EK_RESET: begin
          vis_valid = 1'b0;
          check("reset_out_data", 64'(out_data), 64'(RV));
        end
        EK_FLUSH: vis_valid = 1'b0;
        EK_EN: begin
          if (exp_q.size() > 0 && exp_q[0].due == en_cnt) begin
            vis_valid = 1'b1;
            vis_data  = exp_q[0].data;
            void'(exp_q.pop_front());
          end else begin
            vis_valid = 1'b0;
          end
        end
        default: ;  // stall: whatever was visible stays visible
      endcase
      check("out_valid", 64'(out_valid), 64'(vis_valid));
      if (vis_valid && out_valid) check("out_data", 64'(out_data), 64'(vis_data));
      check("occupancy", 64'(occupancy), 64'(inflight.size()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] bd;
    logic         bv;

    // Bypass instance: combinational, control inputs ignored.
    for (int i = 0; i < 10; i++) begin
      bd = (i == 0) ? 18'h3FFFF : W'($urandom);
      bv = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      byp_reset    = (i % 2 == 0);
      byp_flush    = 1'($urandom_range(0, 1));
      byp_clken    = 1'($urandom_range(0, 1));
      byp_in_data  = bd;
      byp_in_valid = bv;
      #1;
      check("bypass_data", 64'(byp_out_data), 64'(bd));
      check("bypass_valid", 64'(byp_out_valid), 64'(bv));
      check("bypass_occupancy", 64'(byp_occupancy), 64'd0);
    end

    // Reset, then latency/throughput: 1..5 back to back, then drain.
    repeat (2) drive(1, 0, 1, 0, '0);
    for (int i = 1; i <= 5; i++) drive(0, 0, 1, 1, W'(i));
    repeat (5) drive(0, 0, 1, 0, '0);

    // Stall: one item, three disabled cycles, then enough enabled cycles to emerge.
    drive(0, 0, 1, 1, 18'h2A);
    repeat (3) drive(0, 0, 0, 0, '0);
    repeat (4) drive(0, 0, 1, 0, '0);

    // Bubbles 1,0,1,1,0 then drain.
    drive(0, 0, 1, 1, 18'h11);
    drive(0, 0, 1, 0, 18'h22);
    drive(0, 0, 1, 1, 18'h33);
    drive(0, 0, 1, 1, 18'h44);
    drive(0, 0, 1, 0, 18'h55);
    repeat (4) drive(0, 0, 1, 0, '0);

    // Flush with clken on a full pipe while in_valid is high; then with clken low.
    repeat (4) drive(0, 0, 1, 1, W'($urandom));
    drive(0, 1, 1, 1, 18'h3ABCD);
    repeat (4) drive(0, 0, 1, 0, '0);
    repeat (4) drive(0, 0, 1, 1, W'($urandom));
    drive(0, 1, 0, 1, 18'h12345);
    repeat (4) drive(0, 0, 1, 0, '0);

    // Reset mid-stream with clken high, then with clken low; refill after each.
    repeat (3) drive(0, 0, 1, 1, W'($urandom));
    drive(1, 0, 1, 1, 18'h3FFFF);
    repeat (5) drive(0, 0, 1, 1, W'($urandom));
    drive(1, 0, 0, 1, 18'h3FFFF);
    repeat (5) drive(0, 0, 1, 1, W'($urandom));

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), W'($urandom));
    end
    repeat (5) drive(0, 0, 1, 0, '0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
